// File: rtl/riscv_str_ops_seq_pkg.sv
// Shared definitions for the byte-serial string-op unit: op codes, FSM states,
// ASCII bounds and LEET glyphs, plus per-byte helper functions.
package riscv_str_ops_seq_pkg;

  localparam int STR_OP_WIDTH = 3;

  localparam logic [STR_OP_WIDTH-1:0] STR_OP_UPPER = 3'd0;
  localparam logic [STR_OP_WIDTH-1:0] STR_OP_LOWER = 3'd1;
  localparam logic [STR_OP_WIDTH-1:0] STR_OP_LEET  = 3'd2;
  localparam logic [STR_OP_WIDTH-1:0] STR_OP_ROT13 = 3'd3;

  typedef enum logic [1:0] {
    STR_IDLE = 2'd0,
    STR_BUSY = 2'd1,
    STR_DONE = 2'd2
  } str_seq_state_e;

  localparam logic [7:0] ASCII_UC_A       = 8'h41;
  localparam logic [7:0] ASCII_UC_Z       = 8'h5A;
  localparam logic [7:0] ASCII_LC_A       = 8'h61;
  localparam logic [7:0] ASCII_LC_Z       = 8'h7A;
  localparam logic [7:0] ASCII_CASE_DELTA = 8'h20;

  localparam logic [7:0] LEET_GLYPH_A = 8'h34;
  localparam logic [7:0] LEET_GLYPH_E = 8'h33;
  localparam logic [7:0] LEET_GLYPH_I = 8'h31;
  localparam logic [7:0] LEET_GLYPH_O = 8'h30;
  localparam logic [7:0] LEET_GLYPH_S = 8'h35;
  localparam logic [7:0] LEET_GLYPH_T = 8'h37;

  // Caller guarantees b is a letter of the case whose first letter is base.
  function automatic logic [7:0] rot13_byte(input logic [7:0] b, input logic [7:0] base);
    logic [7:0] off;
    off = b - base;
    if (off < 8'd13) begin
      return b + 8'd13;
    end else begin
      return b - 8'd13;
    end
  endfunction

  function automatic logic [7:0] leet_byte(input logic [7:0] b);
    logic [7:0] folded;
    folded = ((b >= ASCII_UC_A) && (b <= ASCII_UC_Z)) ? (b + ASCII_CASE_DELTA) : b;
    case (folded)
      8'h61:   return LEET_GLYPH_A;
      8'h65:   return LEET_GLYPH_E;
      8'h69:   return LEET_GLYPH_I;
      8'h6F:   return LEET_GLYPH_O;
      8'h73:   return LEET_GLYPH_S;
      8'h74:   return LEET_GLYPH_T;
      default: return b;
    endcase
  endfunction

endpackage

// File: rtl/riscv_str_ops_seq_if.sv
// ID/EX/WB handshake bundle of the sequential string-op unit.
interface riscv_str_ops_seq_if;
  import riscv_str_ops_seq_pkg::*;

  logic                    enable_i;
  logic [STR_OP_WIDTH-1:0] operator_i;
  logic [31:0]             operand_i;
  logic                    ex_ready_i;
  logic                    ready_o;
  logic                    valid_o;
  logic [31:0]             result_o;

  modport master (
    output enable_i, operator_i, operand_i, ex_ready_i,
    input  ready_o, valid_o, result_o
  );

  modport slave (
    input  enable_i, operator_i, operand_i, ex_ready_i,
    output ready_o, valid_o, result_o
  );

endinterface

// File: rtl/riscv_str_ops_seq_byte_xform.sv
// Combinational single-byte transform: operator + byte -> byte.
module riscv_str_ops_seq_byte_xform
  import riscv_str_ops_seq_pkg::*;
(
  input  logic [STR_OP_WIDTH-1:0] op,
  input  logic [7:0]              src,
  output logic [7:0]              res
);

  logic is_upper_s;
  logic is_lower_s;

  assign is_upper_s = (src >= ASCII_UC_A) && (src <= ASCII_UC_Z);
  assign is_lower_s = (src >= ASCII_LC_A) && (src <= ASCII_LC_Z);

  // Per-op byte mapping; unknown ops pass the byte through.
  always_comb begin
    res = src;
    case (op)
      STR_OP_UPPER: begin
        if (is_lower_s) res = src - ASCII_CASE_DELTA;
        else            res = src;
      end
      STR_OP_LOWER: begin
        if (is_upper_s) res = src + ASCII_CASE_DELTA;
        else            res = src;
      end
      STR_OP_ROT13: begin
        if (is_upper_s)      res = rot13_byte(src, ASCII_UC_A);
        else if (is_lower_s) res = rot13_byte(src, ASCII_LC_A);
        else                 res = src;
      end
      STR_OP_LEET: res = leet_byte(src);
      default:     res = src;
    endcase
  end

endmodule

// File: rtl/riscv_str_ops_seq.sv
// Multi-cycle byte-serial string-op unit (IDLE -> BUSY -> DONE handshake).
// Optional early completion on a 0x00 byte when STR_OPS_NUL_TERM_EN is defined.
module riscv_str_ops_seq
  import riscv_str_ops_seq_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 1
)(
  input  logic                 clk,
  input  logic                 rst_n,
  riscv_str_ops_seq_if.slave   bus
);

  str_seq_state_e          state_r;
  str_seq_state_e          state_nxt_s;
  logic [STR_OP_WIDTH-1:0] op_r;
  logic [31:0]             data_r;
  logic [31:0]             data_nxt_s;
  logic [1:0]              idx_r;
  logic                    load_s;
  logic                    step_s;
  logic                    last_s;
  logic                    nul_hit_s;
  logic                    ready_s;

  logic [7:0] in_byte_s  [BYTES_PER_CYCLE];
  logic [7:0] out_byte_s [BYTES_PER_CYCLE];

  for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_lane
    assign in_byte_s[g] = data_r[{idx_r + 2'(g), 3'b000} +: 8];

    riscv_str_ops_seq_byte_xform u_xform (
      .op  (op_r),
      .src (in_byte_s[g]),
      .res (out_byte_s[g])
    );
  end

  // Merge transformed lanes back into the word; a NUL stops the lanes above it.
  always_comb begin
    data_nxt_s = data_r;
    nul_hit_s  = 1'b0;
    for (int i = 0; i < BYTES_PER_CYCLE; i++) begin
      if (!nul_hit_s) begin
        data_nxt_s[{idx_r + 2'(i), 3'b000} +: 8] = out_byte_s[i];
`ifdef STR_OPS_NUL_TERM_EN
        if (in_byte_s[i] == 8'h00) nul_hit_s = 1'b1;
        else                       nul_hit_s = 1'b0;
`endif
      end else begin
        nul_hit_s = 1'b1;
      end
    end
  end

  assign last_s = nul_hit_s || (idx_r == 2'(4 - BYTES_PER_CYCLE));

  // Next-state and handshake decode.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    step_s      = 1'b0;
    ready_s     = 1'b0;
    case (state_r)
      STR_IDLE: begin
        ready_s = 1'b1;
        if (bus.enable_i) begin
          load_s      = 1'b1;
          state_nxt_s = STR_BUSY;
        end else begin
          state_nxt_s = STR_IDLE;
        end
      end
      STR_BUSY: begin
        step_s = 1'b1;
        if (last_s) state_nxt_s = STR_DONE;
        else        state_nxt_s = STR_BUSY;
      end
      STR_DONE: begin
        ready_s = bus.ex_ready_i;
        if (bus.ex_ready_i && bus.enable_i) begin
          load_s      = 1'b1;
          state_nxt_s = STR_BUSY;
        end else if (bus.ex_ready_i) begin
          state_nxt_s = STR_IDLE;
        end else begin
          state_nxt_s = STR_DONE;
        end
      end
      default: begin
        state_nxt_s = STR_IDLE;
      end
    endcase
  end

  // State, operator, working word and byte index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= STR_IDLE;
      op_r    <= '0;
      data_r  <= 32'd0;
      idx_r   <= 2'd0;
    end else begin
      state_r <= state_nxt_s;
      if (load_s) begin
        op_r   <= bus.operator_i;
        data_r <= bus.operand_i;
        idx_r  <= 2'd0;
      end else if (step_s) begin
        data_r <= data_nxt_s;
        idx_r  <= idx_r + 2'(BYTES_PER_CYCLE);
      end else begin
        data_r <= data_r;
        idx_r  <= idx_r;
      end
    end
  end

  assign bus.ready_o  = ready_s;
  assign bus.valid_o  = (state_r == STR_DONE);
  assign bus.result_o = (state_r == STR_DONE) ? data_r : 32'd0;

endmodule

// File: tb/tb_riscv_str_ops_seq.sv
// Scoreboard bench for riscv_str_ops_seq: directed ops, backpressure, back-to-back, reset.
module tb_riscv_str_ops_seq;
  import riscv_str_ops_seq_pkg::*;

  localparam int LAT = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [31:0] exp_q [$];

  riscv_str_ops_seq_if bus ();

  riscv_str_ops_seq #(.BYTES_PER_CYCLE(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every retiring result is compared with the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.valid_o && bus.ex_ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: unexpected result %h", bus.result_o);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (bus.result_o !== e) begin
          errors++;
          $display("FAIL result: got %h expected %h", bus.result_o, e);
        end
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] opnd, input logic [31:0] exp);
    bus.enable_i   = 1'b1;
    bus.operator_i = op;
    bus.operand_i  = opnd;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    bus.enable_i = 1'b0;
  endtask

  task automatic wait_valid(output int edges);
    edges = 0;
    while (!bus.valid_o && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] opnd,
                        input logic [31:0] exp, input int lat);
    int n;
    issue(op, opnd, exp);
    check({name, "_busy_ready"}, 32'(bus.ready_o), 32'd0);
    wait_valid(n);
    check({name, "_latency"}, n, lat);
    @(posedge clk); #1;
    check({name, "_idle_ready"}, 32'(bus.ready_o), 32'd1);
  endtask

  initial begin
    int n;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.enable_i   = 1'b0;
    bus.operator_i = '0;
    bus.operand_i  = 32'd0;
    bus.ex_ready_i = 1'b1;
    #12;
    check("rst_ready", 32'(bus.ready_o), 32'd1);
    check("rst_valid", 32'(bus.valid_o), 32'd0);
    check("rst_result", bus.result_o, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_op("upper", STR_OP_UPPER, 32'h64636261, 32'h44434241, LAT);
    run_op("rot13", STR_OP_ROT13, 32'h5A6E6D41, 32'h4D617A4E, LAT);
    run_op("leet", STR_OP_LEET, 32'h74736F65, 32'h37353033, LAT);
    run_op("leet_uc", STR_OP_LEET, 32'h54534F49, 32'h37353031, LAT);
    run_op("lower_bnd", STR_OP_LOWER, 32'h5B5A4140, 32'h5B7A6140, LAT);
    run_op("upper_bnd", STR_OP_UPPER, 32'h7B7A6160, 32'h7B5A4160, LAT);
    run_op("rot13_nonalpha", STR_OP_ROT13, 32'h7B402019, 32'h7B402019, LAT);
    run_op("unknown_op", 3'd7, 32'h12345678, 32'h12345678, LAT);

    // Backpressure with a stray request held through BUSY and DONE.
    bus.ex_ready_i = 1'b0;
    issue(STR_OP_UPPER, 32'h64636261, 32'h44434241);
    bus.enable_i   = 1'b1;
    bus.operator_i = STR_OP_LOWER;
    bus.operand_i  = 32'h41414141;
    wait_valid(n);
    check("bp_latency", n, LAT);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("bp_valid", 32'(bus.valid_o), 32'd1);
      check("bp_ready", 32'(bus.ready_o), 32'd0);
      check("bp_result", bus.result_o, 32'h44434241);
    end
    bus.enable_i   = 1'b0;
    bus.ex_ready_i = 1'b1;
    @(posedge clk); #1;
    check("bp_after_ready", 32'(bus.ready_o), 32'd1);
    check("bp_after_valid", 32'(bus.valid_o), 32'd0);

    // Back-to-back: retire and accept on the same edge.
    issue(STR_OP_LOWER, 32'h44434241, 32'h64636261);
    wait_valid(n);
    check("b2b_first_latency", n, LAT);
    issue(STR_OP_ROT13, 32'h5A6E6D41, 32'h4D617A4E);
    check("b2b_no_bubble_ready", 32'(bus.ready_o), 32'd0);
    check("b2b_no_bubble_valid", 32'(bus.valid_o), 32'd0);
    wait_valid(n);
    check("b2b_second_latency", n, LAT);
    @(posedge clk); #1;

    // Asynchronous reset while BUSY drops the in-flight op.
    issue(STR_OP_UPPER, 32'h64636261, 32'h44434241);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.valid_o), 32'd0);
    check("mid_rst_result", bus.result_o, 32'd0);
    check("mid_rst_ready", 32'(bus.ready_o), 32'd1);
    void'(exp_q.pop_back());
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op("post_rst", STR_OP_LEET, 32'h74736F65, 32'h37353033, LAT);

`ifdef STR_OPS_NUL_TERM_EN
    run_op("nul_mid", STR_OP_LOWER, 32'h41004142, 32'h41006162, 3);
    run_op("nul_first", STR_OP_LOWER, 32'h41424300, 32'h41424300, 1);
`else
    run_op("nul_mid", STR_OP_LOWER, 32'h41004142, 32'h61006162, LAT);
    run_op("nul_first", STR_OP_LOWER, 32'h41424300, 32'h61626300, LAT);
`endif

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
